// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: requests words from memory and presents them in IR
// Three-state fetch FSM; flush redirects PC and overrides ack/stall, reset overrides everything.
module fetch_unit #(
  parameter logic [15:0] PC_RESET = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  input  logic        stall,
  input  logic        flush,
  input  logic [15:0] flush_pc,
  output logic [15:0] IR,
  output logic        ir_valid,
  output logic [15:0] PC
);

  typedef enum logic [1:0] {IDLE, REQ, PRES} state_t;

  state_t state;
  state_t nextState;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= nextState;
  end

  always_comb begin
    nextState = state;
    if (flush) begin
      nextState = IDLE;
    end else begin
      case (state)
        IDLE:    nextState = REQ;
        REQ:     if (mem_ack) nextState = PRES;
        PRES:    if (!stall) nextState = REQ;
        default: nextState = IDLE;
      endcase
    end
  end

  always_comb begin
    mem_req = (state == REQ);
  end

  assign mem_addr = PC;

  // An ack that coincides with a flush is dropped: the flush branch wins before the ack is looked at.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      PC       <= PC_RESET;
      IR       <= 16'h0000;
      ir_valid <= 1'b0;
    end else if (flush) begin
      PC       <= flush_pc;
      IR       <= 16'h0000;
      ir_valid <= 1'b0;
    end else begin
      case (state)
        REQ: begin
          if (mem_ack) begin
            IR       <= mem_rdata;
            ir_valid <= 1'b1;
            PC       <= PC + 16'd1;
          end else begin
            IR       <= 16'h0000;
            ir_valid <= 1'b0;
          end
        end
        PRES: begin
          if (!stall) begin
            IR       <= 16'h0000;
            ir_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
